dma_wr_buf_sched: RTL and testbench

Sequences host-memory write requests for the PCIe DMA write path across four host frame buffers. It latches the four 64-bit buffer base addresses and the start control from the PIO register block. It splits each frame into max-payload write requests for the TLP write engine and rotates buffers 0→1→2→3→0. It withholds a buffer until the host releases it, and raises the frame-done pulse and buffer index that the PIO block exposes to the host.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_wr_buf_sched.sv | 137 +++++++++++++
 tb/tb_dma_wr_buf_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA write-path buffer scheduler.
// Holds the FSM state encoding, buffer count and 4 KB alignment mask.
package dma_pkg;

    localparam int NUM_BUF = 4;
    localparam logic [63:0] ALIGN_4K_MASK = 64'hFFFF_FFFF_FFFF_F000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        WAIT_DATA,
        REQ,
        DONE
    } state_t;

endpackage

// File: rtl/dma_wr_buf_sched.sv
// Splits frames into max-payload host writes rotating over four buffers; request 1 cycle after data.
// Holds request stable while i_req_ready is low; withholds a buffer until the host releases it.
module dma_wr_buf_sched
    import dma_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 4147200,
    parameter int unsigned MAX_PAYLOAD = 256
) (
    input  logic        pcie_clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_cfg_en,
    input  logic [63:0] i_base0,
    input  logic [63:0] i_base1,
    input  logic [63:0] i_base2,
    input  logic [63:0] i_base3,
    input  logic        i_data_avail,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [63:0] o_req_addr,
    output logic [12:0] o_req_len,
    output logic        o_wr_frame_done,
    output logic [1:0]  o_wr_index,
    input  logic        i_buf_release,
    input  logic [1:0]  i_release_idx,
    output logic        o_busy,
    output logic [31:0] o_stall_cnt
);

    localparam logic [31:0] FRAME_LEN = 32'(FRAME_BYTES);
    localparam logic [31:0] PAYLOAD   = 32'(MAX_PAYLOAD);

    state_t             state;
    logic [63:0]        base_q [NUM_BUF];
    logic [NUM_BUF-1:0] free_mask;
    logic [1:0]         cur_idx;
    logic [31:0]        offset;
    logic [31:0]        remain;
    logic [12:0]        len_nxt;
    logic [31:0]        offset_nxt;

    always_comb begin
        remain     = FRAME_LEN - offset;
        len_nxt    = (remain < PAYLOAD) ? remain[12:0] : PAYLOAD[12:0];
        offset_nxt = offset + {19'd0, o_req_len};
    end

    always_ff @(posedge pcie_clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur_idx         <= 2'd0;
            offset          <= 32'd0;
            free_mask       <= '1;
            o_req_valid     <= 1'b0;
            o_req_addr      <= 64'd0;
            o_req_len       <= 13'd0;
            o_wr_frame_done <= 1'b0;
            o_wr_index      <= 2'd0;
            o_busy          <= 1'b0;
            o_stall_cnt     <= 32'd0;
            for (int i = 0; i < NUM_BUF; i++) begin
                base_q[i] <= 64'd0;
            end
        end else begin
            o_wr_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cfg_en) begin
                        base_q[0] <= i_base0 & ALIGN_4K_MASK;
                        base_q[1] <= i_base1 & ALIGN_4K_MASK;
                        base_q[2] <= i_base2 & ALIGN_4K_MASK;
                        base_q[3] <= i_base3 & ALIGN_4K_MASK;
                    end
                    if (i_start) begin
                        state  <= WAIT_BUF;
                        o_busy <= 1'b1;
                    end
                end
                WAIT_BUF: begin
                    if (!i_start) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (free_mask[cur_idx]) begin
                        offset <= 32'd0;
                        state  <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (!i_start) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (i_data_avail) begin
                        o_req_valid <= 1'b1;
                        o_req_addr  <= base_q[cur_idx] + {32'd0, offset};
                        o_req_len   <= len_nxt;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // Once issued, a request always completes its handshake.
                    if (i_req_ready) begin
                        o_req_valid <= 1'b0;
                        offset      <= offset_nxt;
                        if (offset_nxt >= FRAME_LEN) begin
                            state           <= DONE;
                            o_wr_frame_done <= 1'b1;
                            o_wr_index      <= cur_idx;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                DONE: begin
                    cur_idx <= cur_idx + 2'd1;
                    state   <= WAIT_BUF;
                end
                default: begin
                    state       <= IDLE;
                    o_busy      <= 1'b0;
                    o_req_valid <= 1'b0;
                end
            endcase

            if (state == WAIT_BUF && !free_mask[cur_idx] && o_stall_cnt != 32'hFFFF_FFFF) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            // Release is applied after the completion clear so it wins on a collision.
            if (state == DONE) begin
                free_mask[cur_idx] <= 1'b0;
            end
            if (i_buf_release) begin
                free_mask[i_release_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_wr_buf_sched.sv
// Directed bench for dma_wr_buf_sched with a transaction-level model of frame splitting and buffer rotation.
module tb_dma_wr_buf_sched;

    localparam int FB = 1000;
    localparam int MP = 256;

    logic        pcie_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_cfg_en = 1'b0;
    logic [63:0] i_base0 = 64'd0;
    logic [63:0] i_base1 = 64'd0;
    logic [63:0] i_base2 = 64'd0;
    logic [63:0] i_base3 = 64'd0;
    logic        i_data_avail = 1'b0;
    logic        o_req_valid;
    logic        i_req_ready = 1'b0;
    logic [63:0] o_req_addr;
    logic [12:0] o_req_len;
    logic        o_wr_frame_done;
    logic [1:0]  o_wr_index;
    logic        i_buf_release = 1'b0;
    logic [1:0]  i_release_idx = 2'd0;
    logic        o_busy;
    logic [31:0] o_stall_cnt;

    always #5 pcie_clk = ~pcie_clk;

    dma_wr_buf_sched #(.FRAME_BYTES(FB), .MAX_PAYLOAD(MP)) dut (
        .pcie_clk(pcie_clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_en(i_cfg_en),
        .i_base0(i_base0), .i_base1(i_base1), .i_base2(i_base2), .i_base3(i_base3),
        .i_data_avail(i_data_avail), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
        .o_req_addr(o_req_addr), .o_req_len(o_req_len), .o_wr_frame_done(o_wr_frame_done),
        .o_wr_index(o_wr_index), .i_buf_release(i_buf_release), .i_release_idx(i_release_idx),
        .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: expected address stream is base[buffer] + running offset, lengths min(MP, FB - offset).
    logic [63:0] m_base [4];
    bit          m_free [4];
    int          m_idx = 0;
    int          m_off = 0;
    int          m_last = 0;
    bit          m_pend = 1'b0;
    bit          m_en = 1'b0;
    int          n_done = 0;
    logic [63:0] hs_addr [$];
    int          hs_len [$];
    bit          prev_stall = 1'b0;
    bit          prev_hs = 1'b0;
    logic [63:0] prev_addr = 64'd0;
    logic [12:0] prev_len = 13'd0;

    always begin
        @(negedge pcie_clk);
        #1;
        if (!rst_n || !m_en) begin
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            int el;
            chk("done_pulse", 64'(o_wr_frame_done), 64'(m_pend));
            if (m_pend) begin
                m_free[m_idx] = 1'b0;
                m_last = m_idx;
                m_idx  = (m_idx + 1) % 4;
                m_pend = 1'b0;
                n_done++;
            end
            chk("wr_index", 64'(o_wr_index), 64'(m_last));
            if (i_buf_release) m_free[i_release_idx] = 1'b1;
            if (prev_hs) chk("gap_after_hs", 64'(o_req_valid), 64'd0);
            if (prev_stall) begin
                chk("hold_valid", 64'(o_req_valid), 64'd1);
                chk("hold_addr", o_req_addr, prev_addr);
                chk("hold_len", 64'(o_req_len), 64'(prev_len));
            end
            prev_hs = o_req_valid && i_req_ready;
            if (prev_hs) begin
                el = (FB - m_off < MP) ? (FB - m_off) : MP;
                chk("req_addr", o_req_addr, m_base[m_idx] + 64'(m_off));
                chk("req_len", 64'(o_req_len), 64'(el));
                if (m_off == 0) chk("buf_was_free", 64'(m_free[m_idx]), 64'd1);
                hs_addr.push_back(o_req_addr);
                hs_len.push_back(int'(o_req_len));
                m_off += el;
                if (m_off >= FB) begin
                    m_pend = 1'b1;
                    m_off  = 0;
                end
            end
            prev_stall = o_req_valid && !i_req_ready;
            prev_addr  = o_req_addr;
            prev_len   = o_req_len;
        end
    end

    task automatic wait_valid(input int k0, output int k);
        k = k0;
        do begin
            @(negedge pcie_clk);
            k++;
        end while (!o_req_valid && k < 40);
        chk("valid_seen", 64'(o_req_valid), 64'd1);
    endtask

    task automatic wait_ndone(input int target);
        int k = 0;
        while (n_done < target && k < 400) begin
            @(negedge pcie_clk);
            k++;
        end
        chk("frames_done", 64'(n_done), 64'(target));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 40) begin
            @(negedge pcie_clk);
            k++;
        end
        chk("went_idle", 64'(o_busy), 64'd0);
    endtask

    task automatic release_buf(input logic [1:0] idx);
        i_release_idx = idx;
        i_buf_release = 1'b1;
        @(negedge pcie_clk);
        i_buf_release = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(o_req_valid), 64'd0);
        chk({tag, "_addr"}, o_req_addr, 64'd0);
        chk({tag, "_len"}, 64'(o_req_len), 64'd0);
        chk({tag, "_done"}, 64'(o_wr_frame_done), 64'd0);
        chk({tag, "_index"}, 64'(o_wr_index), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_stall"}, 64'(o_stall_cnt), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int h0;
        logic [31:0] s0;

        repeat (3) @(negedge pcie_clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_free[i] = 1'b1;
        @(negedge pcie_clk);
        m_en = 1'b1;

        i_base0 = 64'h1_0000_0000;
        i_base1 = 64'h2_0000_0000;
        i_base2 = 64'h3_0000_5123;
        i_base3 = 64'h4_0000_0000;
        i_cfg_en = 1'b1;
        @(negedge pcie_clk);
        i_cfg_en = 1'b0;
        m_base[0] = 64'h1_0000_0000;
        m_base[1] = 64'h2_0000_0000;
        m_base[2] = 64'h3_0000_5000;
        m_base[3] = 64'h4_0000_0000;

        // Four frames, ready always high.
        i_data_avail = 1'b1;
        i_req_ready  = 1'b1;
        i_start      = 1'b1;
        wait_valid(0, k);
        chk("start_to_valid", 64'(k), 64'd3);
        wait_ndone(4);
        chk("pin_addr0", hs_addr[0], 64'h1_0000_0000);
        chk("pin_addr1", hs_addr[1], 64'h1_0000_0100);
        chk("pin_addr2", hs_addr[2], 64'h1_0000_0200);
        chk("pin_addr3", hs_addr[3], 64'h1_0000_0300);
        chk("pin_len0", 64'(hs_len[0]), 64'd256);
        chk("pin_len3", 64'(hs_len[3]), 64'd232);
        chk("pin_base2_masked", hs_addr[8], 64'h3_0000_5000);
        chk("pin_base3", hs_addr[12], 64'h4_0000_0000);
        chk("index_after4", 64'(o_wr_index), 64'd3);

        // Fifth frame withheld: all buffers in use.
        repeat (3) @(negedge pcie_clk);
        s0 = o_stall_cnt;
        repeat (10) @(negedge pcie_clk);
        chk("stall_delta", 64'(o_stall_cnt - s0), 64'd10);
        chk("stalled_valid", 64'(o_req_valid), 64'd0);
        chk("stalled_busy", 64'(o_busy), 64'd1);

        // Release buffer 0 with ready held low for 5 cycles on the first request.
        i_req_ready   = 1'b0;
        i_release_idx = 2'd0;
        i_buf_release = 1'b1;
        @(negedge pcie_clk);
        i_buf_release = 1'b0;
        wait_valid(1, k);
        chk("release_to_valid", 64'(k), 64'd3);
        for (int c = 0; c < 5; c++) begin
            chk("held_addr", o_req_addr, 64'h1_0000_0000);
            chk("held_len", 64'(o_req_len), 64'd256);
            @(negedge pcie_clk);
        end
        i_req_ready = 1'b1;
        @(negedge pcie_clk);
        i_req_ready = 1'b0;
        wait_valid(0, k);
        chk("one_increment", o_req_addr, 64'h1_0000_0100);
        i_req_ready = 1'b1;
        wait_ndone(5);

        // Stop mid-frame on buffer 1.
        i_req_ready = 1'b0;
        release_buf(2'd1);
        release_buf(2'd2);
        release_buf(2'd3);
        wait_valid(0, k);
        i_req_ready = 1'b1;
        @(negedge pcie_clk);
        i_req_ready = 1'b0;
        wait_valid(0, k);
        chk("stop_req_addr", o_req_addr, 64'h2_0000_0100);
        i_start     = 1'b0;
        i_req_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge pcie_clk);
        chk("no_done_on_stop", 64'(n_done), 64'd5);
        m_off = 0;

        // Restart; cfg while busy must be ignored.
        h0 = hs_addr.size();
        i_start = 1'b1;
        @(negedge pcie_clk);
        i_base0  = 64'hDEAD_0123;
        i_cfg_en = 1'b1;
        @(negedge pcie_clk);
        i_cfg_en = 1'b0;
        wait_ndone(8);
        chk("restart_offset0", hs_addr[h0], 64'h2_0000_0000);

        i_req_ready = 1'b0;
        release_buf(2'd0);
        wait_valid(0, k);
        chk("busy_cfg_ignored", o_req_addr, 64'h1_0000_0000);
        i_start     = 1'b0;
        i_req_ready = 1'b1;
        wait_idle();
        m_off = 0;

        // cfg in IDLE takes effect with low bits cleared.
        i_cfg_en = 1'b1;
        @(negedge pcie_clk);
        i_cfg_en = 1'b0;
        m_base[0] = 64'hDEAD_0000;
        i_req_ready = 1'b0;
        i_start     = 1'b1;
        wait_valid(0, k);
        chk("restart_latency", 64'(k), 64'd3);
        chk("idle_cfg_addr", o_req_addr, 64'hDEAD_0000);
        i_req_ready = 1'b1;

        // Release coinciding with completion of the same buffer.
        k = 0;
        while (!o_wr_frame_done && k < 40) begin
            @(negedge pcie_clk);
            k++;
        end
        chk("done_seen", 64'(o_wr_frame_done), 64'd1);
        chk("done_index0", 64'(o_wr_index), 64'd0);
        i_release_idx = 2'd0;
        i_buf_release = 1'b1;
        @(negedge pcie_clk);
        i_buf_release = 1'b0;
        release_buf(2'd1);
        release_buf(2'd2);
        release_buf(2'd3);
        wait_ndone(12);
        i_req_ready = 1'b0;
        s0 = o_stall_cnt;
        wait_valid(0, k);
        chk("no_stall_after_collision", 64'(o_stall_cnt), 64'(s0));
        chk("collision_buf0_addr", o_req_addr, 64'hDEAD_0000);

        // Reset while a request is pending.
        m_en  = 1'b0;
        rst_n = 1'b0;
        @(negedge pcie_clk);
        chk_reset_outputs("midreq_reset");
        rst_n = 1'b1;
        @(negedge pcie_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
